// File: rtl/mips_regfile_reader.sv
// mips_regfile_reader
//   Read side of a core's 32 x 32-bit general-purpose register file. It also
//   keeps a pending-write scoreboard with one busy bit per register: the bit
//   is set when a producer issues and cleared when its writeback commits.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   rs_addr / rt_addr   read port indices
//   rs_data / rt_data   combinational read data (register 0 reads 0,
//                       write-through bypass from the commit port)
//   rs_busy / rt_busy   register has an uncommitted producer; a register
//                       committing this cycle reads not-busy
//   iss_en, iss_addr    issue of an instruction that will write iss_addr
//   wr_en, wr_addr,
//   wr_data             writeback commit
//   flush               squash: clear every busy bit (the commit still lands)
//   any_busy            OR of the registered busy bits (no bypass term)
//
// The parameters must satisfy 2**ADDR_WIDTH == NUM_REGS.

// One read port. Both ports are identical, so the top instantiates this
// once per port.
module mips_regfile_rd_port #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
    input  logic [NUM_REGS-1:0]                 busy,
    input  logic                                wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic [ADDR_WIDTH-1:0]               addr,
    output logic [DATA_WIDTH-1:0]               data,
    output logic                                busy_out
);
    logic zero;
    logic hit;

    assign zero = (addr == '0);
    assign hit  = wr_en && (wr_addr == addr);

    always_comb begin
        data     = regs[addr];
        busy_out = busy[addr] & ~hit;
        if (zero) begin
            data     = '0;
            busy_out = 1'b0;
        end else if (hit) begin
            data = wr_data;
        end
    end
endmodule

module mips_regfile_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic                  rs_busy,
    output logic                  rt_busy,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush,
    output logic                  any_busy
);
    localparam int NUM_PORTS = 2;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
    logic [NUM_REGS-1:0]                  busy;
    logic [NUM_REGS-1:0]                  busy_nxt;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data;
    logic [NUM_PORTS-1:0]                 port_busy;

    // Storage: writes to register 0 are dropped, so it stays at its reset 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Busy update. The commit clear is applied before the issue set, so a
    // same-cycle issue to the committing register leaves it busy: the new
    // producer supersedes the old one. Flush discards the issue entirely.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_en)
                busy_nxt[wr_addr] = 1'b0;
            if (iss_en)
                busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign any_busy = |busy;

    assign port_addr[0] = rs_addr;
    assign port_addr[1] = rt_addr;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mips_regfile_rd_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .NUM_REGS  (NUM_REGS),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_port (
            .regs    (regs),
            .busy    (busy),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .addr    (port_addr[p]),
            .data    (port_data[p]),
            .busy_out(port_busy[p])
        );
    end

    assign rs_data = port_data[0];
    assign rt_data = port_data[1];
    assign rs_busy = port_busy[0];
    assign rt_busy = port_busy[1];
endmodule

// File: tb/tb_mips_regfile_reader.sv
module tb_mips_regfile_reader;
    logic        clk, reset_n;
    logic [4:0]  rs_addr, rt_addr, iss_addr, wr_addr;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        rs_busy, rt_busy, iss_en, wr_en, flush, any_busy;

    mips_regfile_reader dut (
        .clk(clk), .reset_n(reset_n),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .any_busy(any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] name;
        logic [31:0] rsd;
        logic        rsb;
        logic [31:0] rtd;
        logic        rtb;
        logic        anyb;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    event sample_now;

    task automatic cmp(input logic [95:0] nm, input logic [63:0] fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %0s.%0s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: the outputs are combinational, so they are presented every
    // cycle; sample on the falling edge (or on demand mid-cycle) and check
    // every expectation the driver has queued since the last sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_now);
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "rs_data",  rs_data,         e.rsd);
                cmp(e.name, "rs_busy",  {31'd0, rs_busy}, {31'd0, e.rsb});
                cmp(e.name, "rt_data",  rt_data,         e.rtd);
                cmp(e.name, "rt_busy",  {31'd0, rt_busy}, {31'd0, e.rtb});
                cmp(e.name, "any_busy", {31'd0, any_busy}, {31'd0, e.anyb});
            end
        end
    end

    task automatic expect_out(input logic [95:0] nm, input logic [31:0] rsd,
                              input logic rsb, input logic [31:0] rtd,
                              input logic rtb, input logic anyb);
        exp_t e;
        e.name = nm; e.rsd = rsd; e.rsb = rsb; e.rtd = rtd; e.rtb = rtb; e.anyb = anyb;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ie, input logic [4:0] ia,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic fl, input logic [4:0] ra, input logic [4:0] rb);
        iss_en = ie; iss_addr = ia; wr_en = we; wr_addr = wa; wr_data = wd;
        flush = fl; rs_addr = ra; rt_addr = rb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        expect_out("reset", 0, 0, 0, 0, 0);
        cyc();
        reset_n = 1'b1;

        // Load reg 5 with a value and leave it busy (issue + commit same cycle).
        cyc(); drive(1, 5, 1, 5, 32'hDEADBEEF, 0, 5, 5);
        expect_out("ld5", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 5, 5);
        expect_out("pre_rst", 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 1);
        @(negedge clk); #1;
        // Mid-cycle asynchronous reset, checked before any rising edge.
        reset_n = 1'b0;
        #1;
        expect_out("rst_async", 0, 0, 0, 0, 0);
        -> sample_now;
        cyc();
        expect_out("rst_hold", 0, 0, 0, 0, 0);
        cyc(); reset_n = 1'b1;
        expect_out("rst_rel", 0, 0, 0, 0, 0);

        // Register 0 ignores writes and issues.
        cyc(); drive(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        expect_out("r0_same", 0, 0, 0, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("r0_next", 0, 0, 0, 0, 0);

        // Write-through bypass, then the stored value.
        cyc(); drive(0, 0, 1, 7, 32'h12345678, 0, 7, 7);
        expect_out("byp_same", 32'h12345678, 0, 32'h12345678, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 7, 7);
        expect_out("byp_next", 32'h12345678, 0, 32'h12345678, 0, 0);

        // Scoreboard: issue reg 9, busy for three cycles, commit via bypass.
        cyc(); drive(1, 9, 0, 0, 0, 0, 9, 7);
        expect_out("sb_iss", 0, 0, 32'h12345678, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); drive(0, 0, 0, 0, 0, 0, 9, 7);
            expect_out("sb_busy", 0, 1, 32'h12345678, 0, 1);
        end
        cyc(); drive(0, 0, 1, 9, 32'h0000A5A5, 0, 9, 7);
        expect_out("sb_wb", 32'h0000A5A5, 0, 32'h12345678, 0, 1);
        cyc(); drive(0, 0, 0, 0, 0, 0, 9, 7);
        expect_out("sb_done", 32'h0000A5A5, 0, 32'h12345678, 0, 0);

        // Same-cycle issue and commit to reg 3 while it is busy.
        cyc(); drive(1, 3, 0, 0, 0, 0, 3, 9);
        expect_out("r3_iss", 0, 0, 32'h0000A5A5, 0, 0);
        cyc(); drive(1, 3, 1, 3, 32'h77, 0, 3, 9);
        expect_out("r3_both", 32'h77, 0, 32'h0000A5A5, 0, 1);
        cyc(); drive(0, 0, 0, 0, 0, 0, 3, 9);
        expect_out("r3_after", 32'h77, 1, 32'h0000A5A5, 0, 1);

        // Flush with busy 2, 4, 31 (and 3), plus a same-cycle issue and commit.
        cyc(); drive(1, 2, 0, 0, 0, 0, 3, 31);
        expect_out("fl_i2", 32'h77, 1, 0, 0, 1);
        cyc(); drive(1, 4, 0, 0, 0, 0, 3, 31);
        expect_out("fl_i4", 32'h77, 1, 0, 0, 1);
        cyc(); drive(1, 31, 0, 0, 0, 0, 2, 31);
        expect_out("fl_i31", 0, 1, 0, 0, 1);
        cyc(); drive(1, 6, 1, 4, 32'h44, 1, 4, 31);
        expect_out("fl_cyc", 32'h44, 0, 0, 1, 1);
        cyc(); drive(0, 0, 0, 0, 0, 0, 4, 6);
        expect_out("fl_after", 32'h44, 0, 0, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 3, 31);
        expect_out("fl_clr", 32'h77, 0, 0, 0, 0);

        // Independent issue (12) and commit to a non-busy register (10).
        cyc(); drive(1, 12, 1, 10, 32'h1010, 0, 10, 12);
        expect_out("ind_same", 32'h1010, 0, 0, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 10, 12);
        expect_out("ind_after", 32'h1010, 0, 0, 1, 1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain actual=%0d pending expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_regfile_reader.md
Name: mips_regfile_reader

Overview:
- Read side of the per-core general-purpose register file: 32 x 32-bit storage, two combinational read ports (rs, rt) and one writeback port.
- Includes a pending-write scoreboard. Each register has a busy bit that is set when an instruction writing it issues and cleared when its writeback commits.
- Sits between decode (read/busy query, issue) and writeback (commit) in each of the four core pipelines.
- Supplies operands and hazard status to the stall logic.

Parameters:
- DATA_WIDTH, 32, register data width in bits.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_WIDTH, 5, register index width; must satisfy 2**ADDR_WIDTH == NUM_REGS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs_addr  in  ADDR_WIDTH  read port A index.
- rt_addr  in  ADDR_WIDTH  read port B index.
- rs_data  out  DATA_WIDTH  read port A data (combinational).
- rt_data  out  DATA_WIDTH  read port B data (combinational).
- rs_busy  out  1  port A register has an uncommitted producer.
- rt_busy  out  1  port B register has an uncommitted producer.
- iss_en  in  1  an instruction with destination iss_addr issues this cycle.
- iss_addr  in  ADDR_WIDTH  destination of the issuing instruction.
- wr_en  in  1  writeback commit strobe.
- wr_addr  in  ADDR_WIDTH  writeback destination.
- wr_data  in  DATA_WIDTH  writeback value.
- flush  in  1  pipeline squash: clear all busy bits.
- any_busy  out  1  OR of all busy bits; drain indicator for the core controller.

Behaviour:
- Reset (reset_n low, asynchronous assertion):
  - All registers and all busy bits clear to 0 immediately.
  - rs_data, rt_data read 0; rs_busy, rt_busy, any_busy read 0.
  - Reset deassertion takes effect on the next clk edge.
- Reads are combinational, zero latency:
  - Address 0 always returns 0.
  - If wr_en=1, wr_addr==addr and addr!=0, return wr_data (write-through bypass).
  - Otherwise return the stored register.
- Write: on the rising edge with wr_en=1 and wr_addr!=0, the register takes wr_data. Writes to register 0 are discarded.
- Busy query (combinational):
  - rs_busy = busy[rs_addr] AND NOT (wr_en AND wr_addr==rs_addr).
  - rt_busy is defined the same way on rt_addr.
  - Address 0 always reports 0.
  - A register being committed this cycle therefore reads not-busy, with data supplied by the bypass.
- Busy update, per edge, in priority order:
  1. flush=1: all busy bits are cleared to 0; iss_en that cycle is ignored; wr_en still commits data.
  2. iss_en=1 and iss_addr!=0: busy[iss_addr] is set to 1. This wins over a same-cycle wr_en to the same address, because a new producer supersedes the committing one.
  3. wr_en=1: busy[wr_addr] is cleared to 0, unless it was set in step 2.
  - iss_en to address 0 has no effect.
- Issue and writeback to different addresses in the same cycle are independent: both take effect.
- Writeback to a non-busy register is legal: the data commits and busy stays 0.
- any_busy is combinational from the busy bits as they stand after the last edge, without the bypass term.
- No internal state machine beyond the storage and busy arrays. Throughput is one issue and one commit per cycle.

Test Plan:
- Reset: set regs 5=0xDEADBEEF and busy[5]=1, then pulse reset_n low mid-cycle.
  - rs_addr=5 must read rs_data=0 and rs_busy=0 immediately, before any clk edge.
  - any_busy=0.
- Register 0:
  - wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, iss_en=1, iss_addr=0.
  - Same cycle and next cycle: rs_addr=0 gives rs_data=0, rs_busy=0, any_busy=0.
- Bypass:
  - Cycle N: wr_en=1, wr_addr=7, wr_data=0x12345678, rs_addr=rt_addr=7. Both ports read 0x12345678 in cycle N.
  - After the edge, with wr_en=0, both still read 0x12345678.
- Scoreboard:
  - Issue to reg 9 at cycle 1. rs_busy=1 in cycles 2..4.
  - Writeback reg 9 = 0xA5A5 at cycle 5: rs_busy=0 and rs_data=0xA5A5 in cycle 5 via bypass; busy[9]=0 after the edge.
- Same-cycle issue and writeback to reg 3 (busy[3]=1 beforehand), wr_data=0x77:
  - After the edge, reg 3 = 0x77 and busy[3]=1.
- Flush:
  - Busy regs 2, 4, 31. One cycle with flush=1, iss_en=1 to reg 6, and wr_en to reg 4 = 0x44.
  - After the edge, any_busy=0, busy[6]=0, reg 4 = 0x44.
